cpu_mem_arbiter: RTL and testbench

- Shares the single-port unified instruction/data memory between two requesters: the multicycle CPU core (requester 0) and the DMA engine (requester 1).
- Arbitrates requests and sequences each memory access over a fixed number of wait-state cycles.
- Returns read data and a completion strobe to the granted requester, and detects out-of-range or misaligned accesses.
- Sits between the CPU memory interface / DMA master port and the memory macro.

---
 rtl/cpu_mem_arbiter.sv | 114 +++++++++++
 tb/tb_cpu_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates the CPU core and DMA engine onto the shared single-port memory,
// sequencing each word access over MEM_LAT wait states and flagging bad addresses.
module cpu_mem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_LAT   = 2,
   parameter int MEM_BYTES = 4096,
   parameter int ARB_MODE  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rdy,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rdy,
   output logic [DATA_W-1:0] rdata,
   output logic              acc_err,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   typedef enum logic [2:0] {IDLE, GRANT_ACC, ACCESS, FAULT, DONE} state_t;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t              state, state_nxt;
   logic [3:0]          cnt;
   logic                lat_we, lat_dma, last_dma;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;

   logic                any_req, pick_dma, win_we, win_fault, gnt_pulse;
   logic [ADDR_W-1:0]   win_addr;
   logic [DATA_W-1:0]   win_wdata;

   // On a tie, round-robin favours whoever was not granted last; fixed mode favours the CPU.
   always_comb begin
      any_req   = cpu_req | dma_req;
      pick_dma  = (cpu_req && dma_req) ? ((ARB_MODE == 0) && !last_dma) : dma_req;
      win_we    = pick_dma ? dma_we    : cpu_we;
      win_addr  = pick_dma ? dma_addr  : cpu_addr;
      win_wdata = pick_dma ? dma_wdata : cpu_wdata;
      win_fault = (win_addr >= ADDR_W'(MEM_BYTES)) || (win_addr[1:0] != 2'b00);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = win_fault ? FAULT : ACCESS;
         ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
         FAULT:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Grant coincides with the first memory cycle (counter still at its load value).
   assign gnt_pulse = ((state == ACCESS) && (cnt == LAT_M1)) || (state == FAULT);
   assign cpu_gnt   = gnt_pulse & ~lat_dma;
   assign dma_gnt   = gnt_pulse &  lat_dma;
   assign cpu_rdy   = (state == DONE) & ~lat_dma;
   assign dma_rdy   = (state == DONE) &  lat_dma;
   assign mem_cs    = (state == ACCESS);
   assign mem_we    = mem_cs & lat_we;
   assign mem_addr  = mem_cs ? lat_addr  : '0;
   assign mem_wdata = mem_cs ? lat_wdata : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_dma   <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         last_dma  <= 1'b1;
         rdata     <= '0;
         acc_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (any_req) begin
               lat_we    <= win_we;
               lat_addr  <= win_addr;
               lat_wdata <= win_wdata;
               lat_dma   <= pick_dma;
               last_dma  <= pick_dma;
               cnt       <= LAT_M1;
            end
            ACCESS: if (cnt == 4'd0) begin
               if (!lat_we) rdata <= mem_rdata;
               acc_err <= 1'b0;
            end else begin
               cnt <= cnt - 4'd1;
            end
            FAULT: begin
               rdata   <= '0;
               acc_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed scenarios on round-robin and fixed-priority
// instances, then randomized traffic against a transaction-level model.
module tb_cpu_mem_arbiter;
   localparam int AW = 32, DW = 32, LAT = 2, MB = 4096;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cpu_req, cpu_we, dma_req, dma_we;
   logic [AW-1:0] cpu_addr, dma_addr;
   logic [DW-1:0] cpu_wdata, dma_wdata;

   logic          cpu_gnt0, cpu_rdy0, dma_gnt0, dma_rdy0, acc_err0, mem_cs0, mem_we0;
   logic [AW-1:0] mem_addr0;
   logic [DW-1:0] rdata0, mem_wdata0, mem_rdata0;
   logic          cpu_gnt1, cpu_rdy1, dma_gnt1, dma_rdy1, acc_err1, mem_cs1, mem_we1;
   logic [AW-1:0] mem_addr1;
   logic [DW-1:0] rdata1, mem_wdata1, mem_rdata1;

   logic [DW-1:0] mem0 [1024];
   logic [DW-1:0] mem1 [1024];

   int n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   cpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MEM_BYTES(MB), .ARB_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt0), .cpu_rdy(cpu_rdy0),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt0), .dma_rdy(dma_rdy0),
      .rdata(rdata0), .acc_err(acc_err0),
      .mem_cs(mem_cs0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .mem_rdata(mem_rdata0));

   cpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MEM_BYTES(MB), .ARB_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt1), .cpu_rdy(cpu_rdy1),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt1), .dma_rdy(dma_rdy1),
      .rdata(rdata1), .acc_err(acc_err1),
      .mem_cs(mem_cs1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1));

   function automatic logic [DW-1:0] init_pat(int i);
      return (i == 4) ? 32'hDEAD_BEEF : (32'(i) * 32'h0001_0003 + 32'h5A00_0000);
   endfunction

   // Memory macro stand-ins: contents restored to a known pattern whenever reset is low.
   always @(posedge clk) begin
      if (!rst_n) for (int i = 0; i < 1024; i++) mem0[i] <= init_pat(i);
      else if (mem_cs0 && mem_we0) mem0[mem_addr0[11:2]] <= mem_wdata0;
   end
   always @(posedge clk) begin
      if (!rst_n) for (int i = 0; i < 1024; i++) mem1[i] <= init_pat(i);
      else if (mem_cs1 && mem_we1) mem1[mem_addr1[11:2]] <= mem_wdata1;
   end
   assign mem_rdata0 = mem0[mem_addr0[11:2]];
   assign mem_rdata1 = mem1[mem_addr1[11:2]];

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b0; dma_we = 1'b1;
      cpu_addr = 32'h10; dma_addr = 32'h20; cpu_wdata = 32'h1111_1111; dma_wdata = 32'h2222_2222;
      tick(); tick();
      n_chk++;
      if ({cpu_gnt0, dma_gnt0, cpu_rdy0, dma_rdy0, acc_err0, mem_cs0, mem_we0, mem_addr0, mem_wdata0, rdata0} !== '0)
         $display("FAIL reset_out0 got gnt=%b%b rdy=%b%b err=%b cs=%b we=%b a=%h wd=%h rd=%h exp all 0",
                  cpu_gnt0, dma_gnt0, cpu_rdy0, dma_rdy0, acc_err0, mem_cs0, mem_we0, mem_addr0, mem_wdata0, rdata0);
      else n_pass++;
      n_chk++;
      if ({cpu_gnt1, dma_gnt1, cpu_rdy1, dma_rdy1, acc_err1, mem_cs1, mem_we1, mem_addr1, mem_wdata1, rdata1} !== '0)
         $display("FAIL reset_out1 got gnt=%b%b rdy=%b%b err=%b cs=%b a=%h rd=%h exp all 0",
                  cpu_gnt1, dma_gnt1, cpu_rdy1, dma_rdy1, acc_err1, mem_cs1, mem_addr1, rdata1);
      else n_pass++;
      cpu_req = 1'b0; dma_req = 1'b0; rst_n = 1'b1;
      tick(); tick();
      n_chk++;
      if ({cpu_gnt0, dma_gnt0, cpu_rdy0, dma_rdy0, mem_cs0} !== 5'b0)
         $display("FAIL idle_quiet got %b exp 00000", {cpu_gnt0, dma_gnt0, cpu_rdy0, dma_rdy0, mem_cs0});
      else n_pass++;
   endtask

   task automatic test_cpu_read();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0BAD_0BAD;
      tick();
      n_chk++;
      if ({cpu_gnt0, dma_gnt0, mem_cs0, mem_we0, cpu_rdy0, mem_addr0} !== {5'b10100, 32'h10})
         $display("FAIL rd_gnt got %b a=%h exp 10100 a=10", {cpu_gnt0, dma_gnt0, mem_cs0, mem_we0, cpu_rdy0}, mem_addr0);
      else n_pass++;
      cpu_req = 1'b0; cpu_addr = 32'h44;
      tick();
      n_chk++;
      if ({cpu_gnt0, mem_cs0, mem_we0, cpu_rdy0, mem_addr0} !== {4'b0100, 32'h10})
         $display("FAIL rd_wait got %b a=%h exp 0100 a=10", {cpu_gnt0, mem_cs0, mem_we0, cpu_rdy0}, mem_addr0);
      else n_pass++;
      tick();
      n_chk++;
      if ({cpu_rdy0, dma_rdy0, mem_cs0, acc_err0, rdata0} !== {4'b1000, 32'hDEAD_BEEF})
         $display("FAIL rd_done got %b rd=%h exp 1000 rd=deadbeef", {cpu_rdy0, dma_rdy0, mem_cs0, acc_err0}, rdata0);
      else n_pass++;
      tick();
   endtask

   task automatic test_dma_write();
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'hA5A5_A5A5;
      tick();
      n_chk++;
      if ({dma_gnt0, cpu_gnt0, mem_cs0, mem_we0, mem_addr0, mem_wdata0} !== {4'b1011, 32'h20, 32'hA5A5_A5A5})
         $display("FAIL wr_gnt got %b a=%h wd=%h exp 1011 a=20 wd=a5a5a5a5",
                  {dma_gnt0, cpu_gnt0, mem_cs0, mem_we0}, mem_addr0, mem_wdata0);
      else n_pass++;
      dma_req = 1'b0; dma_wdata = 32'h0;
      tick();
      n_chk++;
      if ({dma_gnt0, mem_cs0, mem_we0, mem_wdata0} !== {3'b011, 32'hA5A5_A5A5})
         $display("FAIL wr_wait got %b wd=%h exp 011 wd=a5a5a5a5", {dma_gnt0, mem_cs0, mem_we0}, mem_wdata0);
      else n_pass++;
      tick();
      n_chk++;
      if ({dma_rdy0, cpu_rdy0, mem_cs0, acc_err0, rdata0, mem0[8]} !== {4'b1000, 32'hDEAD_BEEF, 32'hA5A5_A5A5})
         $display("FAIL wr_done got %b rd=%h mem=%h exp 1000 rd=deadbeef mem=a5a5a5a5",
                  {dma_rdy0, cpu_rdy0, mem_cs0, acc_err0}, rdata0, mem0[8]);
      else n_pass++;
      tick();
   endtask

   task automatic test_fault();
      logic [AW-1:0] bad [2];
      bad[0] = 32'h1000; bad[1] = 32'h6;
      for (int k = 0; k < 2; k++) begin
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = bad[k];
         tick();
         n_chk++;
         if ({cpu_gnt0, mem_cs0, cpu_rdy0} !== 3'b100)
            $display("FAIL fault_gnt[%0d] got %b exp 100", k, {cpu_gnt0, mem_cs0, cpu_rdy0});
         else n_pass++;
         cpu_req = 1'b0;
         tick();
         n_chk++;
         if ({cpu_gnt0, mem_cs0, cpu_rdy0, acc_err0, rdata0} !== {4'b0011, 32'h0})
            $display("FAIL fault_done[%0d] got %b rd=%h exp 0011 rd=0", k, {cpu_gnt0, mem_cs0, cpu_rdy0, acc_err0}, rdata0);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_arbitration();
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80;
      for (int e = 0; e < 16; e++) begin
         logic [1:0] exp0, exp1;
         tick();
         exp0 = (e % 4 != 0) ? 2'b00 : (((e / 4) % 2 == 0) ? 2'b10 : 2'b01);
         exp1 = (e % 4 != 0) ? 2'b00 : 2'b10;
         n_chk++;
         if ({cpu_gnt0, dma_gnt0} !== exp0)
            $display("FAIL rr_order e=%0d got %b exp %b", e, {cpu_gnt0, dma_gnt0}, exp0);
         else n_pass++;
         n_chk++;
         if ({cpu_gnt1, dma_gnt1} !== exp1)
            $display("FAIL fixed_order e=%0d got %b exp %b", e, {cpu_gnt1, dma_gnt1}, exp1);
         else n_pass++;
      end
      cpu_req = 1'b0; dma_req = 1'b0;
   endtask

   task automatic test_reset_abort();
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
      tick();
      cpu_req = 1'b0;
      tick();
      n_chk++;
      if (mem_cs0 !== 1'b1) $display("FAIL abort_cs2 got %b exp 1", mem_cs0);
      else n_pass++;
      rst_n = 1'b0;
      tick();
      n_chk++;
      if ({mem_cs0, cpu_rdy0, dma_rdy0} !== 3'b000)
         $display("FAIL abort_drop got %b exp 000", {mem_cs0, cpu_rdy0, dma_rdy0});
      else n_pass++;
      rst_n = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h14; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h18;
      tick();
      n_chk++;
      if ({cpu_gnt0, dma_gnt0, cpu_rdy0} !== 3'b100)
         $display("FAIL abort_tie got %b exp 100", {cpu_gnt0, dma_gnt0, cpu_rdy0});
      else n_pass++;
      cpu_req = 1'b0;
      repeat (4) tick();
      n_chk++;
      if ({cpu_gnt0, dma_gnt0} !== 2'b01)
         $display("FAIL abort_next got %b exp 01", {cpu_gnt0, dma_gnt0});
      else n_pass++;
      dma_req = 1'b0;
      repeat (3) tick();
   endtask

   // Transaction-level model: each sampling edge picks a winner from the pending
   // requests and schedules its grant/chip-select/completion edges directly.
   task automatic test_random(input int ncyc);
      logic [DW-1:0] smem [1024];
      bit            pend [2];
      bit            pwe  [2];
      logic [AW-1:0] paddr [2];
      logic [DW-1:0] pwd  [2];
      bit            last = 1'b1;
      int            nxt = 0, g_e = -1, r_e = -1, who = 0, w;
      bit            flt = 1'b0, wwe = 1'b0, exp_err = 1'b0;
      logic [AW-1:0] waddr = '0;
      logic [DW-1:0] wwd = '0, exp_rd = '0;
      for (int i = 0; i < 1024; i++) smem[i] = init_pat(i);
      for (int r = 0; r < 2; r++) begin pend[r] = 0; pwe[r] = 0; paddr[r] = '0; pwd[r] = '0; end
      do_reset();
      for (int e = 0; e < ncyc; e++) begin
         bit eg, er, ecs;
         logic [4:0] exp_v;
         if (e == nxt) begin
            if (pend[0] || pend[1]) begin
               w = (pend[0] && pend[1]) ? (last ? 0 : 1) : (pend[1] ? 1 : 0);
               last = (w == 1); who = w;
               flt = (paddr[w] >= 32'(MB)) || (paddr[w][1:0] != 2'b00);
               wwe = pwe[w]; waddr = paddr[w]; wwd = pwd[w];
               g_e = e; r_e = e + (flt ? 1 : LAT); nxt = r_e + 2;
               exp_err = flt;
               if (flt) exp_rd = '0;
               else if (!wwe) exp_rd = smem[waddr[11:2]];
               else smem[waddr[11:2]] = wwd;
            end else nxt = e + 1;
         end
         tick();
         eg  = (e == g_e);
         er  = (e == r_e);
         ecs = !flt && (g_e >= 0) && (e >= g_e) && (e < g_e + LAT);
         exp_v = {eg && who == 0, eg && who == 1, er && who == 0, er && who == 1, ecs};
         n_chk++;
         if ({cpu_gnt0, dma_gnt0, cpu_rdy0, dma_rdy0, mem_cs0} !== exp_v)
            $display("FAIL rnd_ctl e=%0d got %b exp %b", e, {cpu_gnt0, dma_gnt0, cpu_rdy0, dma_rdy0, mem_cs0}, exp_v);
         else n_pass++;
         if (ecs) begin
            n_chk++;
            if ({mem_we0, mem_addr0, (wwe ? mem_wdata0 : wwd)} !== {wwe, waddr, wwd})
               $display("FAIL rnd_mem e=%0d got we=%b a=%h wd=%h exp we=%b a=%h wd=%h",
                        e, mem_we0, mem_addr0, mem_wdata0, wwe, waddr, wwd);
            else n_pass++;
         end
         if (er) begin
            n_chk++;
            if ({rdata0, acc_err0} !== {exp_rd, exp_err})
               $display("FAIL rnd_done e=%0d got rd=%h err=%b exp rd=%h err=%b", e, rdata0, acc_err0, exp_rd, exp_err);
            else n_pass++;
         end
         if (eg) pend[who] = 0;
         for (int r = 0; r < 2; r++) begin
            if (!pend[r] && $urandom_range(0, 2) == 0) begin
               pend[r] = 1; pwe[r] = $urandom_range(0, 1) == 1; pwd[r] = $urandom();
               case ($urandom_range(0, 9))
                  0:       paddr[r] = $urandom() | 32'h1000;
                  1:       paddr[r] = 32'($urandom_range(0, 1023)) * 4 + 32'($urandom_range(1, 3));
                  2:       paddr[r] = 32'hFFC;
                  default: paddr[r] = 32'($urandom_range(0, 1023)) * 4;
               endcase
            end
         end
         cpu_req = pend[0]; cpu_we = pwe[0]; cpu_addr = paddr[0]; cpu_wdata = pwd[0];
         dma_req = pend[1]; dma_we = pwe[1]; dma_addr = paddr[1]; dma_wdata = pwd[1];
      end
   endtask

   initial begin
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
      test_reset();
      test_cpu_read();
      test_dma_write();
      test_fault();
      test_arbitration();
      test_reset_abort();
      test_random(3000);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
